// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: sequential scan picks a matching, free or oldest voice
// per note event, then commits enable/note/age updates and one-cycle trigger pulses.
module voice_alloc #(
  parameter int C_VOICES     = 4,
  parameter int C_NOTE_WIDTH = 7,
  parameter int C_AGE_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             evt_valid,
  output logic                             evt_ready,
  input  logic                             evt_on,
  input  logic [C_NOTE_WIDTH-1:0]          evt_note,
  output logic [C_VOICES-1:0]              voice_en,
  output logic [C_VOICES*C_NOTE_WIDTH-1:0] voice_note,
  output logic [C_VOICES-1:0]              voice_start,
  output logic                             steal
);
  localparam int IW = $clog2(C_VOICES);
  localparam logic [C_AGE_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [IW-1:0] IDX_LAST = IW'(C_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                                   state_q, state_d;
  logic [IW-1:0]                            idx_q, idx_d;
  logic                                     on_q, on_d;
  logic [C_NOTE_WIDTH-1:0]                  note_q, note_d;
  logic [C_VOICES-1:0]                      en_q, en_d, start_q, start_d;
  logic                                     steal_q, steal_d;
  logic [C_VOICES-1:0][C_NOTE_WIDTH-1:0]    vnote_q, vnote_d;
  logic [C_VOICES-1:0][C_AGE_WIDTH-1:0]     age_q, age_d;
  logic                                     match_vld_q, match_vld_d, free_vld_q, free_vld_d;
  logic                                     old_vld_q, old_vld_d;
  logic [IW-1:0]                            match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [IW-1:0]                            old_idx_q, old_idx_d;
  logic [C_AGE_WIDTH-1:0]                   old_age_q, old_age_d;
  logic [IW-1:0]                            tgt;

  assign evt_ready   = (state_q == IDLE);
  assign voice_en    = en_q;
  assign voice_note  = vnote_q;
  assign voice_start = start_q;
  assign steal       = steal_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    en_d        = en_q;
    vnote_d     = vnote_q;
    age_d       = age_q;
    start_d     = '0;
    steal_d     = 1'b0;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    tgt         = '0;
    case (state_q)
      IDLE: begin
        if (evt_valid) begin
          on_d        = evt_on;
          note_d      = evt_note;
          idx_d       = '0;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_vld_d   = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (en_q[idx_q]) begin
          if (!match_vld_q && vnote_q[idx_q] == note_q) begin
            match_vld_d = 1'b1;
            match_idx_d = idx_q;
          end
          // strict compare keeps the lowest index on equal ages
          if (!old_vld_q || age_q[idx_q] > old_age_q) begin
            old_vld_d = 1'b1;
            old_idx_d = idx_q;
            old_age_d = age_q[idx_q];
          end
        end else if (!free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = COMMIT;
      end
      COMMIT: begin
        state_d = IDLE;
        if (on_q) begin
          tgt = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);
          for (int k = 0; k < C_VOICES; k++) begin
            if (IW'(k) == tgt) begin
              en_d[k]    = 1'b1;
              vnote_d[k] = note_q;
              age_d[k]   = '0;
              start_d[k] = 1'b1;
            end else if (en_q[k] && age_q[k] != AGE_MAX) begin
              age_d[k] = age_q[k] + 1'b1;
            end
          end
          steal_d = !match_vld_q && !free_vld_q;
        end else if (match_vld_q) begin
          en_d[match_idx_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // panic wins over everything, including an accept in the same cycle
    if (clear) begin
      en_d    = '0;
      age_d   = '0;
      start_d = '0;
      steal_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      en_q        <= '0;
      vnote_q     <= '0;
      age_q       <= '0;
      start_q     <= '0;
      steal_q     <= 1'b0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      note_q      <= note_d;
      en_q        <= en_d;
      vnote_q     <= vnote_d;
      age_q       <= age_d;
      start_q     <= start_d;
      steal_q     <= steal_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
    end
  end
endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: directed vector table, hand sequences for clear/reset/saturation,
// and random note events against a rule-level allocation model.
module tb_voice_alloc;
  localparam int NV = 4;
  localparam int NW = 7;
  localparam int AW = 8;
  localparam int AGE_SAT = (1 << AW) - 1;

  logic             clk = 1'b0;
  logic             rst, clear, evt_valid, evt_on;
  logic [NW-1:0]    evt_note;
  logic             evt_ready, steal;
  logic [NV-1:0]    voice_en, voice_start;
  logic [NV*NW-1:0] voice_note;

  voice_alloc #(.C_VOICES(NV), .C_NOTE_WIDTH(NW), .C_AGE_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_on(evt_on), .evt_note(evt_note), .voice_en(voice_en), .voice_note(voice_note),
    .voice_start(voice_start), .steal(steal));

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Rule-level model: who plays what, and how long since each was (re)triggered
  bit m_en[NV];
  int m_note[NV];
  int m_age[NV];

  task automatic model_reset(input bit notes_too);
    for (int k = 0; k < NV; k++) begin
      m_en[k] = 0; m_age[k] = 0;
      if (notes_too) m_note[k] = 0;
    end
  endtask

  task automatic model_event(input bit on, input int n, output logic [NV-1:0] st, output logic sl);
    int tgt = -1;
    st = '0; sl = 0;
    for (int k = 0; k < NV; k++) if (tgt < 0 && m_en[k] && m_note[k] == n) tgt = k;
    if (!on) begin
      if (tgt >= 0) m_en[tgt] = 0;
    end else begin
      for (int k = 0; k < NV; k++) if (tgt < 0 && !m_en[k]) tgt = k;
      if (tgt < 0) begin
        sl = 1;
        tgt = 0;
        for (int k = 1; k < NV; k++) if (m_age[k] > m_age[tgt]) tgt = k;
      end
      for (int k = 0; k < NV; k++)
        if (k != tgt && m_en[k]) m_age[k] = (m_age[k] + 1 > AGE_SAT) ? AGE_SAT : m_age[k] + 1;
      m_en[tgt] = 1; m_note[tgt] = n; m_age[tgt] = 0; st[tgt] = 1'b1;
    end
  endtask

  function automatic logic [NV-1:0] m_en_vec();
    logic [NV-1:0] v;
    for (int k = 0; k < NV; k++) v[k] = m_en[k];
    return v;
  endfunction

  function automatic logic [NV*NW-1:0] m_note_vec();
    logic [NV*NW-1:0] v;
    for (int k = 0; k < NV; k++) v[k*NW +: NW] = NW'(m_note[k]);
    return v;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (evt_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (evt_ready !== 1'b1) check("ready_timeout", {63'd0, evt_ready}, 64'd1);
  endtask

  // One event through the handshake; compares against the model and returns what was seen
  task automatic do_evt(input bit on, input int n, output logic [NV-1:0] a_en,
                        output logic [NV-1:0] a_st, output logic a_sl, output logic [NV*NW-1:0] a_nt);
    int lows = 0;
    logic [NV-1:0] e_st;
    logic e_sl;
    wait_ready();
    evt_valid = 1; evt_on = on; evt_note = NW'(n);
    @(negedge clk);
    evt_valid = 0; evt_on = 1'($urandom); evt_note = NW'($urandom);
    while (evt_ready === 1'b0 && lows < 20) begin lows++; @(negedge clk); end
    check("busy_cycles", 64'(lows), 64'(NV + 1));
    model_event(on, n, e_st, e_sl);
    a_en = voice_en; a_st = voice_start; a_sl = steal; a_nt = voice_note;
    check("model_en", 64'(voice_en), 64'(m_en_vec()));
    check("model_note", 64'(voice_note), 64'(m_note_vec()));
    check("model_start", 64'(voice_start), 64'(e_st));
    check("model_steal", 64'(steal), 64'(e_sl));
    @(negedge clk);
    check("pulse_clear", 64'({voice_start, steal}), 64'd0);
  endtask

  typedef struct {
    bit            on;
    int            note;
    logic [NV-1:0] en;
    logic [NV-1:0] start;
    logic          stl;
    logic [NV*NW-1:0] notes;
  } vec_t;
  vec_t tbl[9];

  logic [NV-1:0] a_en, a_st;
  logic a_sl;
  logic [NV*NW-1:0] a_nt;
  time t_acc[3];

  initial begin
    tbl[0] = '{1, 60, 4'b0001, 4'b0001, 1'b0, {7'd0,  7'd0,  7'd0,  7'd60}};
    tbl[1] = '{1, 62, 4'b0011, 4'b0010, 1'b0, {7'd0,  7'd0,  7'd62, 7'd60}};
    tbl[2] = '{1, 64, 4'b0111, 4'b0100, 1'b0, {7'd0,  7'd64, 7'd62, 7'd60}};
    tbl[3] = '{1, 65, 4'b1111, 4'b1000, 1'b0, {7'd65, 7'd64, 7'd62, 7'd60}};
    tbl[4] = '{1, 67, 4'b1111, 4'b0001, 1'b1, {7'd65, 7'd64, 7'd62, 7'd67}};
    tbl[5] = '{0, 62, 4'b1101, 4'b0000, 1'b0, {7'd65, 7'd64, 7'd62, 7'd67}};
    tbl[6] = '{1, 69, 4'b1111, 4'b0010, 1'b0, {7'd65, 7'd64, 7'd69, 7'd67}};
    tbl[7] = '{0, 50, 4'b1111, 4'b0000, 1'b0, {7'd65, 7'd64, 7'd69, 7'd67}};
    tbl[8] = '{1, 64, 4'b1111, 4'b0100, 1'b0, {7'd65, 7'd64, 7'd69, 7'd67}};

    rst = 1; clear = 0; evt_valid = 0; evt_on = 0; evt_note = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_ready", {63'd0, evt_ready}, 64'd1);
    check("rst_outputs", 64'({voice_en, voice_note, voice_start, steal}), 64'd0);
    model_reset(1);

    // held valid: accepts land exactly NV+2 cycles apart
    evt_valid = 1; evt_on = 1; evt_note = 7'd60;
    for (int a = 0; a < 3; a++) begin
      wait_ready();
      @(posedge clk); t_acc[a] = $time;
      @(negedge clk); evt_note = NW'(62 + 2 * a);
    end
    evt_valid = 0;
    check("accept_gap1", 64'(t_acc[1] - t_acc[0]), 64'((NV + 2) * 10));
    check("accept_gap2", 64'(t_acc[2] - t_acc[1]), 64'((NV + 2) * 10));
    repeat (NV + 2) @(negedge clk);
    check("held_en", 64'(voice_en), 64'b0111);
    check("held_notes", 64'(voice_note), 64'({7'd0, 7'd64, 7'd62, 7'd60}));

    rst = 1; @(negedge clk); rst = 0;
    model_reset(1);

    for (int i = 0; i < 9; i++) begin
      do_evt(tbl[i].on, tbl[i].note, a_en, a_st, a_sl, a_nt);
      check($sformatf("tbl%0d_en", i), 64'(a_en), 64'(tbl[i].en));
      check($sformatf("tbl%0d_start", i), 64'(a_st), 64'(tbl[i].start));
      check($sformatf("tbl%0d_steal", i), 64'(a_sl), 64'(tbl[i].stl));
      check($sformatf("tbl%0d_notes", i), 64'(a_nt), 64'(tbl[i].notes));
      if (i == 4) check("steal_age_v1", 64'(dut.age_q[1]), 64'd3);
      if (i == 8) check("retrig_age_v2", 64'(dut.age_q[2]), 64'd0);
    end

    // clear two cycles into a scan aborts the event
    wait_ready();
    evt_valid = 1; evt_on = 1; evt_note = 7'd70;
    @(negedge clk); evt_valid = 0;
    @(negedge clk); clear = 1;
    @(negedge clk); clear = 0;
    model_reset(0);
    check("clr_en", 64'(voice_en), 64'd0);
    check("clr_ready", {63'd0, evt_ready}, 64'd1);
    check("clr_pulses", 64'({voice_start, steal}), 64'd0);
    repeat (NV + 2) @(negedge clk);
    check("clr_no_late", 64'(voice_en), 64'd0);
    check("clr_notes_kept", 64'(voice_note), 64'(m_note_vec()));

    // clear in the same cycle as an accept discards the event
    evt_valid = 1; evt_on = 1; evt_note = 7'd71; clear = 1;
    @(negedge clk); evt_valid = 0; clear = 0;
    check("clr_acc_ready", {63'd0, evt_ready}, 64'd1);
    repeat (NV + 2) @(negedge clk);
    check("clr_acc_en", 64'(voice_en), 64'd0);

    for (int i = 0; i < 150; i++)
      do_evt($urandom_range(0, 99) < 65, 60 + $urandom_range(0, 9), a_en, a_st, a_sl, a_nt);

    // reset mid-scan loses the event
    wait_ready();
    evt_valid = 1; evt_on = 1; evt_note = 7'd90;
    @(negedge clk); evt_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    model_reset(1);
    check("rst_mid_out", 64'({voice_en, voice_note, voice_start, steal}), 64'd0);
    check("rst_mid_ready", {63'd0, evt_ready}, 64'd1);
    repeat (NV + 2) @(negedge clk);
    check("rst_mid_late", 64'(voice_en), 64'd0);

    // age saturation: voice 0 held while voice 1 retriggers
    do_evt(1, 10, a_en, a_st, a_sl, a_nt);
    for (int i = 0; i < 300; i++) do_evt(1, 20, a_en, a_st, a_sl, a_nt);
    check("sat_age_v0", 64'(dut.age_q[0]), 64'(m_age[0]));
    check("sat_age_v0_max", 64'(dut.age_q[0]), 64'(AGE_SAT));
    check("sat_age_v1", 64'(dut.age_q[1]), 64'(m_age[1]));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
